// File: rtl/md_ctrl_pkg.sv
// Shared definitions for the E-stage multiply/divide sequencer.
package md_defs;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned CNT_W = 8;

  localparam logic [OP_W-1:0] MD_NONE  = 3'd0;
  localparam logic [OP_W-1:0] MD_MULT  = 3'd1;
  localparam logic [OP_W-1:0] MD_MULTU = 3'd2;
  localparam logic [OP_W-1:0] MD_DIV   = 3'd3;
  localparam logic [OP_W-1:0] MD_DIVU  = 3'd4;
  localparam logic [OP_W-1:0] MD_MTHI  = 3'd5;
  localparam logic [OP_W-1:0] MD_MTLO  = 3'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic is_md_long(input logic [OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_md_mult(input logic [OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath; a zero divisor leaves HI/LO unchanged.
module md_arith
  import md_defs::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     op_a,
  input  logic [31:0]     op_b,
  input  logic [31:0]     cur_hi,
  input  logic [31:0]     cur_lo,
  output logic [31:0]     res_hi,
  output logic [31:0]     res_lo
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] b_nz;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] smag_q;
  logic [31:0] smag_r;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] sq;
  logic [31:0] sr;

  // Low 64 bits of the sign-extended product equal the signed product.
  assign prod_s = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
  assign prod_u = {32'd0, op_a} * {32'd0, op_b};

  assign b_nz = (op_b == 32'd0) ? 32'd1 : op_b;
  assign uq   = op_a / b_nz;
  assign ur   = op_a % b_nz;

  // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 naturally.
  assign mag_a  = op_a[31] ? (32'd0 - op_a) : op_a;
  assign mag_b  = op_b[31] ? (32'd0 - op_b) : op_b;
  assign smag_q = mag_a / ((mag_b == 32'd0) ? 32'd1 : mag_b);
  assign smag_r = mag_a % ((mag_b == 32'd0) ? 32'd1 : mag_b);
  assign sq     = (op_a[31] ^ op_b[31]) ? (32'd0 - smag_q) : smag_q;
  assign sr     = op_a[31] ? (32'd0 - smag_r) : smag_r;

  always_comb begin
    res_hi = cur_hi;
    res_lo = cur_lo;
    case (op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: begin
        if (op_b != 32'd0) begin
          res_hi = sr;
          res_lo = sq;
        end
      end
      MD_DIVU: begin
        if (op_b != 32'd0) begin
          res_hi = ur;
          res_lo = uq;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: latency counter, HI/LO ownership and D-stage stall request.
module md_ctrl
  import md_defs::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     src_a,
  input  logic [31:0]     src_b,
  input  logic            d_md_use,
  output logic            start,
  output logic            busy,
  output logic [31:0]     hi,
  output logic [31:0]     lo,
  output logic            stall_req
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             busy_q;
  logic             start_w;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;

  md_arith u_arith (
    .op     (op_q),
    .op_a   (a_q),
    .op_b   (b_q),
    .cur_hi (hi_q),
    .cur_lo (lo_q),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  // Next-state, counter and HI/LO update.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    start_w = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid && is_md_long(op)) begin
          start_w = 1'b1;
          state_d = ST_RUN;
          count_d = is_md_mult(op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          op_d    = op;
          a_d     = src_a;
          b_d     = src_b;
        end else if (op_valid && (op == MD_MTHI)) begin
          hi_d = src_a;
        end else if (op_valid && (op == MD_MTLO)) begin
          lo_d = src_a;
        end
      end
      ST_RUN: begin
        // op_valid here is a protocol violation and is deliberately ignored.
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          count_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      op_q    <= MD_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= (state_d == ST_RUN);
    end
  end

  assign start     = start_w;
  assign busy      = busy_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign stall_req = d_md_use & (start_w | busy_q);

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: latency, arithmetic corner cases, HI/LO moves, stall and reset.
module tb_md_ctrl;
  import md_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        d_md_use;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall_req;

  int total = 0;
  int bad   = 0;

  md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .d_md_use  (d_md_use),
    .start     (start),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one long op and check every cycle until the result is visible.
  // inj_mtlo presents an mtlo mid-run, which must be ignored.
  task automatic run_md(input string tag, input logic [2:0] code, input logic [31:0] a,
                        input logic [31:0] b, input logic use_d, input int n,
                        input logic inj_mtlo, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(posedge clk); #1;
    op_valid = 1'b1; op = code; src_a = a; src_b = b; d_md_use = use_d;
    @(negedge clk);
    check({tag, ".start"}, 32'(start), 32'd1);
    check({tag, ".busy0"}, 32'(busy), 32'd0);
    check({tag, ".stall0"}, 32'(stall_req), 32'(use_d));
    @(posedge clk); #1;
    op_valid = 1'b0; src_a = ~a; src_b = ~b;
    for (int i = 0; i < n; i++) begin
      if (inj_mtlo && i == 2) begin
        op_valid = 1'b1; op = MD_MTLO; src_a = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      check($sformatf("%s.busy[%0d]", tag, i), 32'(busy), 32'd1);
      check($sformatf("%s.nostart[%0d]", tag, i), 32'(start), 32'd0);
      check($sformatf("%s.stall[%0d]", tag, i), 32'(stall_req), 32'(use_d));
      @(posedge clk); #1;
      op_valid = 1'b0;
    end
    @(negedge clk);
    check({tag, ".busy_done"}, 32'(busy), 32'd0);
    check({tag, ".stall_done"}, 32'(stall_req), 32'd0);
    check({tag, ".hi"}, hi, exp_hi);
    check({tag, ".lo"}, lo, exp_lo);
    d_md_use = 1'b0;
  endtask

  initial begin
    reset = 1'b0; op_valid = 1'b0; op = MD_NONE; src_a = '0; src_b = '0; d_md_use = 1'b0;
    #12;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.hi", hi, 32'd0);
    check("rst.lo", lo, 32'd0);
    check("rst.start", 32'(start), 32'd0);
    @(negedge clk); reset = 1'b1;

    // mthi / mtlo while idle
    @(posedge clk); #1;
    op_valid = 1'b1; op = MD_MTHI; src_a = 32'h1234_5678; d_md_use = 1'b1;
    @(negedge clk);
    check("mthi.start", 32'(start), 32'd0);
    check("mthi.stall", 32'(stall_req), 32'd0);
    check("mthi.hi_before", hi, 32'd0);
    @(posedge clk); #1;
    op = MD_MTLO; src_a = 32'hA5A5_A5A5; d_md_use = 1'b0;
    @(negedge clk);
    check("mthi.hi", hi, 32'h1234_5678);
    check("mthi.busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(negedge clk);
    check("mtlo.lo", lo, 32'hA5A5_A5A5);

    // Reset during cycle 3 of a divide aborts it with no commit.
    @(posedge clk); #1;
    op_valid = 1'b1; op = MD_DIVU; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    check("abort.busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.hi", hi, 32'd0);
    check("abort.lo", lo, 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("abort.busy_after", 32'(busy), 32'd0);
    check("abort.hi_after", hi, 32'd0);
    check("abort.lo_after", lo, 32'd0);

    run_md("mult",  MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 5,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_md("multu", MD_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 5,  1'b0, 32'h0000_0002, 32'hFFFF_FFFA);
    run_md("div",   MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu0", MD_DIVU,  32'h0000_0007, 32'h0000_0000, 1'b0, 10, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divovf", MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10, 1'b0, 32'h0000_0000, 32'h8000_0000);
    run_md("divneg", MD_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 10, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD);
    run_md("divu",  MD_DIVU,  32'd100,       32'd7,         1'b1, 10, 1'b1, 32'd2,         32'd14);
    run_md("multx", MD_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0, 5,  1'b0, 32'h4000_0000, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
